// File: rtl/demux_thicc_pkg.sv
// Shared constants for the demux_thicc 1-to-16 registered demultiplexer.
package demux_thicc_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_thicc_decode.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module demux_thicc_decode
  import demux_thicc_pkg::*;
(
  input  logic              en_i,
  input  sel_t              sel_i,
  output logic [NUM_CH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux_thicc.sv
// Registered 1-to-16 demultiplexer with per-channel valid/ready and a transfer counter.
// Define DEMUX_THICC_AUTO_SEL_EN to replace in_sel with an internal round-robin pointer.
module demux_thicc
  import demux_thicc_pkg::*;
#(
  parameter int unsigned dw = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [dw-1:0]     in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [dw-1:0]     out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  xfer_count
);

  logic             state_q, state_d;
  logic [dw-1:0]    data_q, data_d;
  sel_t             hsel_q, hsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sel_t             sel_src;
  logic             accept;
  logic             deliver;

`ifdef DEMUX_THICC_AUTO_SEL_EN
  sel_t ptr_q, ptr_d;
  logic unused_in_sel;

  assign unused_in_sel = ^in_sel;
  assign sel_src       = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + sel_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign sel_src = in_sel;
`endif

  // Only the selected consumer's ready matters; others can never complete a transfer.
  assign deliver  = (state_q == StFull) & out_ready[hsel_q];
  assign in_ready = (state_q == StEmpty) | out_ready[hsel_q];
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hsel_d  = hsel_q;
    if (accept) begin
      state_d = StFull;
      data_d  = in_data;
      hsel_d  = sel_src;
    end else if (deliver) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      hsel_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hsel_q  <= hsel_d;
      cnt_q   <= cnt_d;
    end
  end

  demux_thicc_decode u_decode (
    .en_i     (state_q == StFull),
    .sel_i    (hsel_q),
    .onehot_o (out_valid)
  );

  assign out_data   = data_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_demux_thicc.sv
// Randomised scoreboard bench for demux_thicc (dw=8); follows DEMUX_THICC_AUTO_SEL_EN if defined.
module tb_demux_thicc;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [3:0]    sel;
    logic [DW-1:0] data;
  } item_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [3:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   out_valid;
  logic [15:0]   out_ready;
  logic [15:0]   xfer_count;

  int    checks;
  int    errors;
  item_t q[$];
  int    model_cnt;
  int    model_ptr;

  demux_thicc #(.dw(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on the falling edge, compare DUT outputs with the occupancy model and
  // retire the held word when the selected consumer is ready.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [15:0] exp_valid;
      logic        exp_ready;
      exp_valid = (q.size() == 0) ? 16'h0 : (16'h1 << q[0].sel);
      exp_ready = (q.size() == 0) || out_ready[q[0].sel];
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("xfer_count", 32'(xfer_count), 32'(model_cnt[15:0]));
      if (q.size() != 0 && out_ready[q[0].sel]) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        void'(q.pop_front());
        model_cnt = (model_cnt + 1) % 65536;
      end
    end
  end

  // Producer-side capture: record each accepted word after the monitor has run.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && in_valid && in_ready) begin
      item_t it;
`ifdef DEMUX_THICC_AUTO_SEL_EN
      it.sel   = 4'(model_ptr);
      model_ptr = (model_ptr + 1) % 16;
`else
      it.sel   = in_sel;
`endif
      it.data  = in_data;
      q.push_back(it);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 0;
    model_ptr = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 16'h0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_xfer_count", 32'(xfer_count), 32'h0);
    step();

    // Single transfer to channel 3
    out_ready = 16'hFFFF;
    in_data   = 8'hA5;
    in_sel    = 4'd3;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("single_count", 32'(xfer_count), 32'h1);

    // Backpressure on channel 9
    out_ready = 16'hFFFF & ~(16'h1 << 9);
    in_data   = 8'h3C;
    in_sel    = 4'd9;
    in_valid  = 1'b1;
    step();
    in_data  = 8'hFF;
    in_sel   = 4'd2;
    repeat (4) begin
      step();
      chk("bp_data_stable", 32'(out_data), 32'h3C);
    end
    in_valid  = 1'b0;
    out_ready = 16'hFFFF;
    step();
    step();
    chk("bp_count", 32'(xfer_count), 32'h2);

    // Back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      in_data  = 8'(8'h40 + i);
      in_sel   = 4'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_count", 32'(xfer_count), 32'd18);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sel    = 4'($urandom_range(0, 15));
      out_ready = (i % 50 < 25) ? 16'($urandom) : 16'hFFFF;
      step();
    end

    // Drain with bounded wait
    in_valid  = 1'b0;
    out_ready = 16'hFFFF;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    step();
    chk("drain_empty", 32'(q.size()), 32'h0);

    // Asynchronous reset while FULL to channel 5
    out_ready = 16'hFFFF & ~(16'h1 << 5);
    in_data   = 8'h77;
    in_sel    = 4'd5;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_xfer_count", 32'(xfer_count), 32'h0);
    q.delete();
    model_cnt = 0;
    model_ptr = 0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
